// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC select encodings, reset PC and NOP word.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned INDEX_W  = 26;
    localparam int unsigned NPC_OP_W = 2;

    typedef enum logic [NPC_OP_W-1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/decode control in, fetch address and IF/ID contents out.
interface fetch_stage_if;
    import mips_pkg::*;

    logic                stall;
    logic [XLEN-1:0]     instr_f;
    logic [NPC_OP_W-1:0] npc_op;
    logic                br;
    logic [IMM_W-1:0]    imm16_d;
    logic [INDEX_W-1:0]  index26_d;
    logic [XLEN-1:0]     rs_val_d;
    logic [XLEN-1:0]     pc_f;
    logic [XLEN-1:0]     instr_d;
    logic [XLEN-1:0]     pc_d;
    logic [XLEN-1:0]     pc8_d;

    modport master (
        output stall, instr_f, npc_op, br, imm16_d, index26_d, rs_val_d,
        input  pc_f, instr_d, pc_d, pc8_d
    );

    modport slave (
        input  stall, instr_f, npc_op, br, imm16_d, index26_d, rs_val_d,
        output pc_f, instr_d, pc_d, pc8_d
    );

endinterface

// File: rtl/npc_sel.sv
// Combinational next-PC selection: sequential, conditional branch, J/JAL, JR/JALR.
module npc_sel
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]     pc_f_i,
    input  logic [XLEN-1:0]     pc_d_i,
    input  logic [NPC_OP_W-1:0] npc_op_i,
    input  logic                br_i,
    input  logic [IMM_W-1:0]    imm16_d_i,
    input  logic [INDEX_W-1:0]  index26_d_i,
    input  logic [XLEN-1:0]     rs_val_d_i,
    output logic [XLEN-1:0]     npc_o
);

    logic [XLEN-1:0] br_off;

    // Word offset, sign-extended; branch base is the delay-slot address pc_d+4.
    assign br_off = {{(XLEN-IMM_W-2){imm16_d_i[IMM_W-1]}}, imm16_d_i, 2'b00};

    always_comb begin
        npc_o = pc_f_i + XLEN'(4);
        case (npc_op_i)
            NPC_BR: if (br_i) npc_o = pc_d_i + XLEN'(4) + br_off;
            NPC_J:  npc_o = {pc_d_i[XLEN-1:XLEN-4], index26_d_i, 2'b00};
            NPC_JR: npc_o = rs_val_d_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: program counter plus IF/ID pipeline register (one delay slot, no flush).
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  fs
);

    logic [XLEN-1:0] pc_f_q,    pc_f_d;
    logic [XLEN-1:0] instr_d_q, instr_d_d;
    logic [XLEN-1:0] pc_d_q,    pc_d_d;
    logic [XLEN-1:0] npc;

    npc_sel u_npc_sel (
        .pc_f_i      (pc_f_q),
        .pc_d_i      (pc_d_q),
        .npc_op_i    (fs.npc_op),
        .br_i        (fs.br),
        .imm16_d_i   (fs.imm16_d),
        .index26_d_i (fs.index26_d),
        .rs_val_d_i  (fs.rs_val_d),
        .npc_o       (npc)
    );

    // Stall freezes everything; a branch in ID is simply re-evaluated next cycle.
    always_comb begin
        pc_f_d    = pc_f_q;
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        if (!fs.stall) begin
            pc_f_d    = npc;
            instr_d_d = fs.instr_f;
            pc_d_d    = pc_f_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            instr_d_q <= NOP;
            pc_d_q    <= '0;
        end else begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
        end
    end

    assign fs.pc_f    = pc_f_q;
    assign fs.instr_d = instr_d_q;
    assign fs.pc_d    = pc_d_q;
    assign fs.pc8_d   = pc_d_q + XLEN'(8);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random traffic against a PC-level model.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_stage_if fs ();

    fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (fs)
    );

    always #5 clk = ~clk;

    // Instruction memory stand-in: a distinct word for every address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    assign fs.instr_f = imem(fs.pc_f);

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  op;
        logic        br;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic [31:0] e_pcf;
        logic [31:0] e_pcd;
        logic        e_nop;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic [1:0] op, input logic b,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
        reset        = rst;
        fs.stall     = st;
        fs.npc_op    = op;
        fs.br        = b;
        fs.imm16_d   = imm;
        fs.index26_d = idx;
        fs.rs_val_d  = rs;
    endtask

    task automatic check_all(input int step, input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] ins);
        check("pc_f",    step, fs.pc_f,    pcf);
        check("pc_d",    step, fs.pc_d,    pcd);
        check("instr_d", step, fs.instr_d, ins);
        check("pc8_d",   step, fs.pc8_d,   pcd + 32'd8);
    endtask

    // Reference model state: architectural PC, and what sits in the IF/ID latch.
    logic [31:0] m_pc, m_pd, m_id;

    function automatic logic [31:0] ref_next(input logic [1:0] op, input logic b, input logic [15:0] imm,
                                             input logic [25:0] idx, input logic [31:0] rs);
        int signed words;
        words = $signed(imm);
        if (op == 2'd1 && b) return m_pd + 32'd4 + 32'(words * 4);
        if (op == 2'd2)      return (m_pd & 32'hF000_0000) | (32'(idx) << 2);
        if (op == 2'd3)      return rs;
        return m_pc + 32'd4;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);

        // Reset, sequential run, branch taken/not taken, J, JR, stalled branch, reset+stall, wrap.
        vq.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 32'h0, 1'b1});
        vq.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 32'h0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 16'h1234, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_3000, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3008, 32'h0000_3004, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_3008, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3010, 32'h0000_300C, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3014, 32'h0000_3010, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_3014, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3008, 32'h0000_3004, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_3008, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3010, 32'h0000_300C, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3014, 32'h0000_3010, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 32'h0000_3018, 32'h0000_3014, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_301C, 32'h0000_3018, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3020, 32'h0000_301C, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3024, 32'h0000_3020, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 26'h0000C10, 32'h0, 32'h0000_3040, 32'h0000_3024, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h0000_3101, 32'h0000_3101, 32'h0000_3040, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3105, 32'h0000_3101, 1'b0});
        vq.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 32'h0000_3105, 32'h0000_3101, 1'b0});
        vq.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 16'h0010, 26'h0, 32'h0, 32'h0000_3105, 32'h0000_3101, 1'b0});
        vq.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 32'h0000_3105, 32'h0000_3101, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 16'h0010, 26'h0, 32'h0, 32'h0000_3109, 32'h0000_3105, 1'b0});
        vq.push_back('{1'b1, 1'b1, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 32'h0000_3000, 32'h0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 32'h0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3000, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_0004, 32'h0000_0000, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b1, 16'h8000, 26'h0, 32'h0, 32'hFFFE_0004, 32'h0000_0004, 1'b0});

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].stall, vq[i].op, vq[i].br, vq[i].imm, vq[i].idx, vq[i].rs);
            @(posedge clk);
            #1;
            check_all(i, vq[i].e_pcf, vq[i].e_pcd, vq[i].e_nop ? 32'h0 : imem(vq[i].e_pcd));
        end

        // Random traffic; the first cycle resets so model and DUT start aligned.
        m_pc = 32'h0;
        m_pd = 32'h0;
        m_id = 32'h0;
        for (int k = 0; k < 400; k++) begin
            logic        r, s, b;
            logic [1:0]  op;
            logic [15:0] imm;
            logic [25:0] idx;
            logic [31:0] rs;
            r   = (k == 0) || ($urandom_range(0, 49) == 0);
            s   = ($urandom_range(0, 3) == 0);
            op  = 2'($urandom_range(0, 3));
            b   = 1'($urandom);
            imm = 16'($urandom);
            idx = 26'($urandom);
            rs  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            @(negedge clk);
            drive(r, s, op, b, imm, idx, rs);
            @(posedge clk);
            if (r) begin
                m_pc = 32'h0000_3000;
                m_pd = 32'h0;
                m_id = 32'h0;
            end else if (!s) begin
                logic [31:0] nxt;
                nxt  = ref_next(op, b, imm, idx, rs);
                m_id = imem(m_pc);
                m_pd = m_pc;
                m_pc = nxt;
            end
            #1;
            check_all(1000 + k, m_pc, m_pd, m_id);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
